// File: rtl/note_draw_sequencer_pkg.sv
// Shared constants, FSM state type and colour helper for the note draw sequencer.
package note_draw_sequencer_pkg;

  localparam int unsigned SCREEN_W      = 160;
  localparam int unsigned SCREEN_H      = 120;
  localparam int unsigned SHAPE_SIZE    = 61;
  localparam int unsigned DEF_NUM_LANES = 2;
  localparam int unsigned DEF_Y_MAX     = SCREEN_H - SHAPE_SIZE;

  localparam logic [2:0] COLOUR_ERASE = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ERASE_ISSUE,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_ISSUE,
    S_DRAW_WAIT,
    S_NEXT
  } seq_state_t;

  function automatic logic [2:0] lane_colour(input int unsigned lane);
    return 3'(lane + 1);
  endfunction

endpackage

// File: rtl/note_draw_sequencer_lane_slot.sv
// One note lane: active bit, y position, pending spawn and bottom-retire compare.
module note_lane_slot #(
  parameter int unsigned Y_MAX  = 59,
  parameter int unsigned Y_STEP = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spawn,
  input  logic       i_commit,
  input  logic       i_advance,
  input  logic       i_retire,
  output logic       o_active,
  output logic       o_pending,
  output logic [6:0] o_y,
  output logic [6:0] o_yNext,
  output logic       o_atBottom
);

  logic       r_active;
  logic       r_pending;
  logic [6:0] r_y;
  logic [7:0] w_ySum;

  // 8-bit sum so a step past 127 cannot wrap below Y_MAX
  assign w_ySum     = {1'b0, r_y} + 8'(Y_STEP);
  assign o_atBottom = (w_ySum > 8'(Y_MAX));
  assign o_yNext    = w_ySum[6:0];
  assign o_active   = r_active;
  assign o_pending  = r_pending;
  assign o_y        = r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active  <= 1'b0;
      r_pending <= 1'b0;
      r_y       <= '0;
    end else if (i_commit) begin
      r_active  <= 1'b1;
      r_pending <= 1'b0;
      r_y       <= '0;
    end else begin
      if (i_spawn && !r_active) r_pending <= 1'b1;
      if (i_retire)       r_active <= 1'b0;
      else if (i_advance) r_y      <= o_yNext;
    end
  end

endmodule

// File: rtl/note_draw_sequencer.sv
// Per-frame scheduler: erases, advances and redraws each lane's note via the shape drawer.
module note_draw_sequencer
  import note_draw_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
  parameter int unsigned LANE_X0    = 10,
  parameter int unsigned LANE_PITCH = 80,
  parameter int unsigned Y_MAX      = DEF_Y_MAX,
  parameter int unsigned Y_STEP     = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 frameTick,
  input  logic [NUM_LANES-1:0] spawn,
  input  logic                 shapeDone,
  output logic                 startingAddressLoaded,
  output logic [7:0]           originX,
  output logic [6:0]           originY,
  output logic [2:0]           colour,
  output logic                 busy,
  output logic [NUM_LANES-1:0] noteMissed,
  output logic                 frameDropped
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  seq_state_t          r_state, w_next;
  logic [LANE_W-1:0]   r_lane;
  logic                r_pendingFrame;
  logic                r_waited;
  logic                w_laneClr, w_laneInc;
  logic                w_commitSel, w_advanceSel, w_retireSel;
  logic [NUM_LANES-1:0] w_active, w_pending, w_atBottom;
  logic [NUM_LANES-1:0] w_commit, w_advance, w_retire;
  logic [6:0]          w_y     [NUM_LANES];
  logic [6:0]          w_yNext [NUM_LANES];
  logic [7:0]          w_laneX;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    note_lane_slot #(
      .Y_MAX  (Y_MAX),
      .Y_STEP (Y_STEP)
    ) u_slot (
      .i_clk      (clock),
      .i_rst_n    (resetn),
      .i_spawn    (spawn[g]),
      .i_commit   (w_commit[g]),
      .i_advance  (w_advance[g]),
      .i_retire   (w_retire[g]),
      .o_active   (w_active[g]),
      .o_pending  (w_pending[g]),
      .o_y        (w_y[g]),
      .o_yNext    (w_yNext[g]),
      .o_atBottom (w_atBottom[g])
    );
  end

  assign w_laneX = 8'(LANE_X0 + LANE_PITCH * r_lane);
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_laneClr    = 1'b0;
    w_laneInc    = 1'b0;
    w_commitSel  = 1'b0;
    w_advanceSel = 1'b0;
    w_retireSel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frameTick || r_pendingFrame) begin
          w_laneClr = 1'b1;
          w_next    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_pending[r_lane]) begin
          w_commitSel = 1'b1;
          w_next      = S_DRAW_ISSUE;
        end else if (w_active[r_lane]) begin
          w_next = S_ERASE_ISSUE;
        end else begin
          w_next = S_NEXT;
        end
      end
      S_ERASE_ISSUE: w_next = S_ERASE_WAIT;
      S_ERASE_WAIT:  if (r_waited && shapeDone) w_next = S_UPDATE;
      S_UPDATE: begin
        if (w_atBottom[r_lane]) begin
          w_retireSel = 1'b1;
          w_next      = S_NEXT;
        end else begin
          w_advanceSel = 1'b1;
          w_next       = S_DRAW_ISSUE;
        end
      end
      S_DRAW_ISSUE: w_next = S_DRAW_WAIT;
      S_DRAW_WAIT:  if (r_waited && shapeDone) w_next = S_NEXT;
      S_NEXT: begin
        if (r_lane == LANE_W'(NUM_LANES - 1)) begin
          w_next = S_IDLE;
        end else begin
          w_laneInc = 1'b1;
          w_next    = S_SCAN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_commit  = '0;
    w_advance = '0;
    w_retire  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      w_commit[i]  = w_commitSel  && (r_lane == LANE_W'(i));
      w_advance[i] = w_advanceSel && (r_lane == LANE_W'(i));
      w_retire[i]  = w_retireSel  && (r_lane == LANE_W'(i));
    end
  end

  // Origin/colour load on entry to an ISSUE state so they are valid alongside the start pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lane                <= '0;
      r_pendingFrame        <= 1'b0;
      r_waited              <= 1'b0;
      startingAddressLoaded <= 1'b0;
      originX               <= '0;
      originY               <= '0;
      colour                <= '0;
      noteMissed            <= '0;
      frameDropped          <= 1'b0;
    end else begin
      r_waited <= ((r_state == S_ERASE_WAIT) || (r_state == S_DRAW_WAIT)) && (w_next == r_state);

      if (w_laneClr)      r_lane <= '0;
      else if (w_laneInc) r_lane <= r_lane + 1'b1;

      frameDropped <= 1'b0;
      if (r_state == S_IDLE) begin
        r_pendingFrame <= 1'b0;
      end else if (frameTick) begin
        if (r_pendingFrame) frameDropped <= 1'b1;
        r_pendingFrame <= 1'b1;
      end

      startingAddressLoaded <= (w_next == S_ERASE_ISSUE) || (w_next == S_DRAW_ISSUE);
      if (w_next == S_ERASE_ISSUE) begin
        originX <= w_laneX;
        originY <= w_y[r_lane];
        colour  <= COLOUR_ERASE;
      end else if (w_next == S_DRAW_ISSUE) begin
        originX <= w_laneX;
        originY <= (r_state == S_SCAN) ? 7'd0 : w_yNext[r_lane];
        colour  <= lane_colour(32'(r_lane));
      end

      noteMissed <= w_retire;
    end
  end

endmodule

// File: tb/tb_note_draw_sequencer.sv
// Scoreboard bench for note_draw_sequencer with a 3-cycle drawer model.
module tb_note_draw_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       frameTick;
  logic [1:0] spawn;
  logic       shapeDone;
  logic       startingAddressLoaded;
  logic [7:0] originX;
  logic [6:0] originY;
  logic [2:0] colour;
  logic       busy;
  logic [1:0] noteMissed;
  logic       frameDropped;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } shape_t;

  shape_t sb[$];
  shape_t last_shape;
  shape_t mon_e;
  int     vectors = 0;
  int     miscompares = 0;
  int     missCnt0 = 0;
  int     missCnt1 = 0;
  int     dropCnt = 0;
  int     drawCnt = 0;

  always #5 clock = ~clock;

  note_draw_sequencer #(
    .NUM_LANES  (2),
    .LANE_X0    (10),
    .LANE_PITCH (80),
    .Y_MAX      (59),
    .Y_STEP     (1)
  ) dut (
    .clock                 (clock),
    .resetn                (resetn),
    .frameTick             (frameTick),
    .spawn                 (spawn),
    .shapeDone             (shapeDone),
    .startingAddressLoaded (startingAddressLoaded),
    .originX               (originX),
    .originY               (originY),
    .colour                (colour),
    .busy                  (busy),
    .noteMissed            (noteMissed),
    .frameDropped          (frameDropped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    shape_t s;
    s.x = 8'(x);
    s.y = 7'(y);
    s.c = 3'(c);
    sb.push_back(s);
  endtask

  // Drawer: drops shapeDone the cycle after start, raises it 3 cycles later.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shapeDone <= 1'b1;
      drawCnt   <= 0;
    end else if (startingAddressLoaded) begin
      shapeDone <= 1'b0;
      drawCnt   <= 3;
    end else if (drawCnt > 0) begin
      drawCnt <= drawCnt - 1;
      if (drawCnt == 1) shapeDone <= 1'b1;
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (startingAddressLoaded) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_shape: got x=%0d y=%0d c=%0d expected none", originX, originY, colour);
        end else begin
          mon_e = sb.pop_front();
          chk("shape", {14'b0, originX, originY, colour}, {14'b0, mon_e});
          last_shape = mon_e;
        end
      end else if (busy && !shapeDone) begin
        chk("held_origin", {14'b0, originX, originY, colour}, {14'b0, last_shape});
      end
      if (noteMissed[0]) missCnt0++;
      if (noteMissed[1]) missCnt1++;
      if (frameDropped)  dropCnt++;
    end
  end

  task automatic tick();
    @(negedge clock) frameTick = 1'b1;
    @(negedge clock) frameTick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_idle"}, 32'(n < 3000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn    = 1'b0;
    frameTick = 1'b0;
    spawn     = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {19'b0, startingAddressLoaded, originX, originY, colour, busy, noteMissed, frameDropped}, 0);
    resetn = 1'b1;

    // Spawn lane 0 then a frame: draw only
    @(negedge clock) spawn = 2'b01;
    @(negedge clock) spawn = 2'b00;
    push(10, 0, 1);
    tick();
    wait_idle("spawn_draw");

    // Erase then redraw one row down; check start latency
    push(10, 0, 0);
    push(10, 1, 1);
    @(negedge clock) frameTick = 1'b1;
    @(posedge clock) #1 chk("busy_after_tick", 32'(busy), 1);
    @(negedge clock) frameTick = 1'b0;
    @(posedge clock) #1 chk("start_latency", 32'(startingAddressLoaded), 1);
    wait_idle("first_move");

    for (int f = 3; f <= 60; f++) begin
      push(10, f - 2, 0);
      push(10, f - 1, 1);
      tick();
      wait_idle("fall");
    end
    chk("no_miss_yet", 32'(missCnt0), 0);

    // Bottom: erase at 59, retire, no draw
    push(10, 59, 0);
    tick();
    wait_idle("retire");
    chk("miss_lane0", 32'(missCnt0), 1);
    tick();
    wait_idle("empty_pass");
    chk("miss_lane0_after", 32'(missCnt0), 1);

    // Both lanes spawned on the same cycle as a frame tick
    push(10, 0, 1);
    push(90, 0, 2);
    @(negedge clock) begin spawn = 2'b11; frameTick = 1'b1; end
    @(negedge clock) begin spawn = 2'b00; frameTick = 1'b0; end
    wait_idle("two_spawn");
    push(10, 0, 0); push(10, 1, 1); push(90, 0, 0); push(90, 1, 2);
    tick();
    wait_idle("two_lane_move");

    // Three ticks in one pass: one drop, exactly one extra pass
    chk("no_drop_yet", 32'(dropCnt), 0);
    push(10, 1, 0); push(10, 2, 1); push(90, 1, 0); push(90, 2, 2);
    push(10, 2, 0); push(10, 3, 1); push(90, 2, 0); push(90, 3, 2);
    tick();
    tick();
    tick();
    wait_idle("double_pass");
    repeat (20) @(negedge clock);
    chk("quiet_after_extra", 32'(busy), 0);
    chk("drop_count", 32'(dropCnt), 1);
    chk("miss_lane1", 32'(missCnt1), 0);

    // Reset during lane 0 DRAW_WAIT
    push(10, 3, 0);
    push(10, 4, 1);
    tick();
    n = 0;
    while (!(startingAddressLoaded && colour == 3'd1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("reach_draw", 32'(n < 200), 1);
    @(negedge clock);
    chk("in_draw_wait", {30'b0, busy, shapeDone}, 32'b10);
    resetn = 1'b0;
    #1;
    chk("reset_mid_draw", {19'b0, startingAddressLoaded, originX, originY, colour, busy, noteMissed, frameDropped}, 0);
    chk("sb_drained", 32'(sb.size()), 0);
    @(negedge clock) resetn = 1'b1;
    tick();
    wait_idle("post_reset_pass");
    chk("post_reset_miss", 32'(missCnt0 + missCnt1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_draw_sequencer.md
# note_draw_sequencer

Per-frame scheduler for falling note blocks, directly upstream of the square-shape drawer FSM. On each frame tick it walks every lane: erases an active note at its old position, advances it down the screen, then redraws it. For each erase or draw it hands the drawer an origin (x, y) and colour with a one-cycle start pulse, then waits for the drawer's done flag. Lanes whose note passes the bottom are retired and reported as missed.

## Interface
- NUM_LANES, 2: number of note lanes / slots (one note per lane).
- LANE_X0, 10: x origin of lane 0 (pixels).
- LANE_PITCH, 80: x spacing between lanes.
- Y_MAX, 59: last legal top-left y (120 rows − 61-row shape).
- Y_STEP, 1: rows advanced per frame.
- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frameTick  in  1  one-cycle pulse at frame rate.
- spawn  in  NUM_LANES  one-cycle per-lane pulse requesting a new note at y=0.
- shapeDone  in  1  drawer idle/done level; high when drawer is idle.
- startingAddressLoaded  out  1  one-cycle start pulse to drawer.
- originX  out  8  shape top-left x.
- originY  out  7  shape top-left y.
- colour  out  3  000 for erase, lane colour for draw (lane i = i+1, 3 bits).
- busy  out  1  high whenever not in IDLE.
- noteMissed  out  NUM_LANES  one-cycle pulse when a lane's note retires off the bottom.
- frameDropped  out  1  one-cycle pulse when a frameTick arrives with one already pending.

## Operation
- Per-lane state: active bit, y[6:0]. Pending-spawn bits, pending-frame flag.
- spawn[i] sets pendingSpawn[i] on any cycle; ignored if lane i already active. Pending spawns commit (active=1, y=0, no erase) in SCAN for that lane, before draw.
- States: IDLE, SCAN, ERASE_ISSUE, ERASE_WAIT, UPDATE, DRAW_ISSUE, DRAW_WAIT, NEXT.
- IDLE: if frameTick or pendingFrame → lane=0, SCAN; clear pendingFrame.
- SCAN: lane inactive and no pending spawn → NEXT. Pending spawn → commit, DRAW_ISSUE. Active → ERASE_ISSUE.
- ERASE_ISSUE: drive originX = LANE_X0 + lane·LANE_PITCH, originY = y, colour = 000; startingAddressLoaded=1 → ERASE_WAIT.
- *_WAIT: first cycle unconditionally waits (drawer has not yet dropped shapeDone); thereafter advance when shapeDone=1.
- UPDATE: if y + Y_STEP > Y_MAX → active=0, noteMissed[lane] pulse, NEXT; else y += Y_STEP, DRAW_ISSUE.
- DRAW_ISSUE: as erase but colour = lane+1; → DRAW_WAIT → NEXT.
- NEXT: lane == NUM_LANES−1 → IDLE, else lane+1 → SCAN.
- frameTick while busy: set pendingFrame; if already set, pulse frameDropped (flag stays set).
- y arithmetic in 8 bits to avoid wrap at compare.

## Timing
- Reset (resetn=0, async): state IDLE, all lanes inactive, y=0, pending bits clear; all outputs 0.
- frameTick in IDLE → SCAN next cycle; first startingAddressLoaded 2 cycles after tick for an active lane 0.
- originX/originY/colour registered; set in ISSUE cycle, held stable until the WAIT state exits.
- startingAddressLoaded high exactly one cycle per shape.
- Spawn and frameTick on the same cycle: spawn is pending and commits within that frame's pass.
- resetn asserted mid-draw: sequencer returns to IDLE immediately; drawer reset independently.

## Structure
- Shared package: lane count, screen dims (160×120), shape size 61, colour constants (ERASE=000), state encoding localparams.
- One natural sub-module: note_lane_slot (active bit, y register, pending spawn, retire compare), instantiated NUM_LANES times; sequencer FSM in top.

## Test plan
- Spawn lane 0, frameTick, drawer model with 3-cycle done delay → one draw: originX=10, originY=0, colour=001; no erase.
- Next frameTick → erase at (10,0,000) then draw at (10,1,001), in that order, one pulse each.
- Note at y=59, frameTick → erase at y=59, noteMissed[0] pulse, no draw, lane inactive.
- Both lanes active → order lane0 erase/draw, lane1 erase/draw at originX=90; colour lane1 = 010.
- Two frameTicks during one busy pass → one frameDropped pulse; exactly one extra pass follows.
- resetn low while in DRAW_WAIT → outputs 0, busy=0 same cycle; no lanes active afterwards.
